window_line_buffer: RTL and testbench
=====================================

Name: window_line_buffer

Overview:
Parametrised successor to the fixed 3x3 pixel_loader. Takes a raster-order pixel stream and emits one KxK neighbourhood window per image pixel, centred on that pixel, with programmable border handling. Frame geometry is known, so the block self-flushes the trailing rows at end of frame. Sits between any two stages of the canny chain, for example gaussian_filter to gradient_calculation.

Parameters:
IMG_W, 512, pixels per line (>= K)
IMG_H, 512, lines per frame (>= K)
PIX_W, 8, bits per pixel
K, 3, window size; odd, 3..7; R = K/2
BORDER, 0, 0 = zero padding, 1 = replicate nearest edge pixel

Ports:
clk  in  1  clock, rising edge
rstN  in  1  reset, synchronous, active-low
pixel_in  in  PIX_W  input pixel, raster order
pixel_in_valid  in  1  pixel_in valid this cycle
pixel_in_ready  out  1  block accepts a pixel this cycle; accept = valid & ready
window_out  out  K*K*PIX_W  window; element (i,j) (i row top-down, j col left-right) at bits [(i*K+j)*PIX_W +: PIX_W]
window_out_valid  out  1  window_out valid, single-cycle qualifier
out_row  out  $clog2(IMG_H)  centre row of the current window
out_col  out  $clog2(IMG_W)  centre column of the current window
frame_done  out  1  pulses with the last window of a frame

Behaviour:
- Reset (rstN=0 at posedge): all outputs 0, except pixel_in_ready=1 from the first cycle after reset. Counters cleared, state FILL. Line storage contents are don't-care; padding must mask them. Reset mid-frame discards the partial frame.
- Handshake: no output backpressure. Input gaps are allowed. The output sequence must not depend on the gap pattern.
- Latency: H_OFF = R*IMG_W + R. Accepting input index n (n = r*IMG_W + c) produces the window centred on index n-H_OFF on the next cycle.
- States:
  - FILL: the first H_OFF accepted pixels produce no output. Go to RUN after H_OFF accepts.
  - RUN: each accept produces one window. On acceptance of the last pixel (IMG_H-1, IMG_W-1), go to FLUSH.
  - FLUSH: pixel_in_ready=0. The block emits H_OFF windows back-to-back, one per cycle, with out-of-image rows/cols padded. frame_done is asserted together with the window centred at (IMG_H-1, IMG_W-1). Next cycle: state FILL, ready=1.
- Border handling:
  - Any window element whose source row or column lies outside the image is 0 when BORDER=0.
  - When BORDER=1, such an element takes the value at the row and column clamped into the image.
  - Line-wrap pixels of the shift window must never leak into a window.
- Storage: K-1 line delays of IMG_W x PIX_W each, plus a KxK register array.
- out_row/out_col: increment with each emitted window, wrapping at IMG_W; reset to 0 per frame.
- Simultaneous events: the last-pixel accept and the first flush window are on consecutive cycles. A new frame's first pixel can be accepted the cycle after frame_done.

Decomposition:
- canny_pkg holds:
  - typedef border_e {BORDER_ZERO, BORDER_REPL}
  - function win_idx(i,j)
  - state enum {FILL, RUN, FLUSH}
- Sub-module line_delay: parametrised IMG_W-deep, PIX_W-wide delay line with enable; circular RAM plus pointer. K-1 instances.
- Border muxing and counters stay in window_line_buffer.

Test Plan (IMG_W=8, IMG_H=6, K=3, PIX_W=8, pixel value = r*8+c):
- Reset: hold rstN=0 for 3 cycles -> all outputs 0. pixel_in_ready=1 after the first post-reset clock. No valid before input.
- Zero pad, continuous input:
  - First window_out_valid on the cycle after the 10th accept, centre (0,0).
  - Rows: [0,0,0] [0,0,1] [0,8,9].
  - Total 48 windows.
  - Window (2,3) = [10,11,12] [18,19,20] [26,27,28].
- Replicate (BORDER=1): window (0,0) = [0,0,1] [0,0,1] [8,8,9]. Window (5,7) = [38,39,39] [46,47,47] [46,47,47].
- Random 50% valid gaps -> window and coordinate sequence identical to the continuous case.
- Flush and back-to-back frames:
  - After the 48th accept, ready=0 for exactly 9 cycles, with 9 consecutive valid windows.
  - frame_done on window (5,7).
  - A second frame starting the next cycle yields a correct (0,0) window with no stale pixels in zero mode.
- Reset asserted after 20 accepts, then a full frame -> output equals the clean-frame case exactly. No frame_done for the aborted frame.

Source files
------------

// File: rtl/canny_pkg.sv
// rtl/canny_pkg.sv - shared types and helpers for the canny window stages
package canny_pkg;

    typedef enum logic [0:0] {
        BORDER_ZERO = 1'b0,
        BORDER_REPL = 1'b1
    } border_e;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // Flat index of window element (row i, column j) in a k-wide window
    function automatic int win_idx(input int i, input int j, input int k);
        return i * k + j;
    endfunction

endpackage

// File: rtl/line_delay.sv
// rtl/line_delay.sv - DEPTH-deep enabled delay line built from a circular RAM
module line_delay
    import canny_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;

    // Read-before-write at the same slot yields the sample from DEPTH enables ago
    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/window_line_buffer.sv
// rtl/window_line_buffer.sv - raster stream to centred KxK windows with border handling
module window_line_buffer
    import canny_pkg::*;
#(
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512,
    parameter int PIX_W  = 8,
    parameter int K      = 3,
    parameter int BORDER = 0
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic [PIX_W-1:0]          pixel_in,
    input  logic                      pixel_in_valid,
    output logic                      pixel_in_ready,
    output logic [K*K*PIX_W-1:0]      window_out,
    output logic                      window_out_valid,
    output logic [$clog2(IMG_H)-1:0]  out_row,
    output logic [$clog2(IMG_W)-1:0]  out_col,
    output logic                      frame_done
);

    localparam int R     = K / 2;
    localparam int H_OFF = R * IMG_W + R;
    localparam int RW    = $clog2(IMG_H);
    localparam int CW    = $clog2(IMG_W);
    localparam int NW    = $clog2(H_OFF + 1);
    localparam int IW    = $clog2(K);
    localparam border_e MODE = (BORDER != 0) ? BORDER_REPL : BORDER_ZERO;

    state_e             state;
    logic [NW-1:0]      phase_cnt;
    logic [RW-1:0]      in_row;
    logic [CW-1:0]      in_col;
    logic [RW-1:0]      ctr_row;
    logic [CW-1:0]      ctr_col;
    logic               ready_q;
    logic               accept;
    logic               step;
    logic               emit;
    logic               last_in;
    logic [PIX_W-1:0]   step_pix;

    logic [PIX_W-1:0]   ld_out  [K-1];
    logic [PIX_W-1:0]   new_col [K];
    logic [PIX_W-1:0]   hist    [K][K-1];
    logic [PIX_W-1:0]   nraw    [K][K];
    logic [K*K*PIX_W-1:0] win_next;

    int                 sr;
    int                 sc;
    int                 si;
    int                 sj;
    logic               is_out;

    assign pixel_in_ready = ready_q;
    assign accept   = pixel_in_valid & ready_q;
    assign step     = accept | (state == FLUSH);
    assign emit     = ((state == RUN) & accept) | (state == FLUSH);
    assign step_pix = accept ? pixel_in : '0;
    assign last_in  = (in_row == RW'(IMG_H - 1)) && (in_col == CW'(IMG_W - 1));

    // Row K-1 of the incoming column is the live pixel; older rows come from the delay chain
    assign new_col[K-1] = step_pix;

    for (genvar m = 0; m < K - 1; m++) begin : g_ld
        logic [PIX_W-1:0] din;
        if (m == 0) begin : g_first
            assign din = step_pix;
        end else begin : g_chain
            assign din = ld_out[m-1];
        end
        line_delay #(
            .DEPTH (IMG_W),
            .WIDTH (PIX_W)
        ) u_line_delay (
            .clk  (clk),
            .rstN (rstN),
            .en   (step),
            .din  (din),
            .dout (ld_out[m])
        );
        assign new_col[K-2-m] = ld_out[m];
    end

    // nraw is the shift window as it will look after this step
    for (genvar i = 0; i < K; i++) begin : g_row
        for (genvar j = 0; j < K; j++) begin : g_col
            if (j < K - 1) begin : g_hist
                assign nraw[i][j] = hist[i][j];
            end else begin : g_new
                assign nraw[i][j] = new_col[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (step) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) begin
                    hist[i][j] <= nraw[i][j+1];
                end
            end
        end
    end

    // Out-of-image taps either read as zero or redirect to the clamped in-image tap,
    // which always lies inside the same shift window, so wrapped pixels never leak.
    always_comb begin
        win_next = '0;
        sr       = 0;
        sc       = 0;
        si       = 0;
        sj       = 0;
        is_out   = 1'b0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                sr     = int'(ctr_row) + i - R;
                sc     = int'(ctr_col) + j - R;
                is_out = (sr < 0) || (sr >= IMG_H) || (sc < 0) || (sc >= IMG_W);
                if (sr < 0) begin
                    sr = 0;
                end else if (sr > IMG_H - 1) begin
                    sr = IMG_H - 1;
                end
                if (sc < 0) begin
                    sc = 0;
                end else if (sc > IMG_W - 1) begin
                    sc = IMG_W - 1;
                end
                si = sr - int'(ctr_row) + R;
                sj = sc - int'(ctr_col) + R;
                if (!(is_out && (MODE == BORDER_ZERO))) begin
                    win_next[win_idx(i, j, K)*PIX_W +: PIX_W] = nraw[si[IW-1:0]][sj[IW-1:0]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state            <= FILL;
            phase_cnt        <= '0;
            in_row           <= '0;
            in_col           <= '0;
            ctr_row          <= '0;
            ctr_col          <= '0;
            ready_q          <= 1'b0;
            window_out       <= '0;
            window_out_valid <= 1'b0;
            out_row          <= '0;
            out_col          <= '0;
            frame_done       <= 1'b0;
        end else begin
            window_out_valid <= emit;
            frame_done       <= 1'b0;
            ready_q          <= 1'b1;

            if (emit) begin
                window_out <= win_next;
                out_row    <= ctr_row;
                out_col    <= ctr_col;
                if (ctr_col == CW'(IMG_W - 1)) begin
                    ctr_col <= '0;
                    ctr_row <= ctr_row + RW'(1);
                end else begin
                    ctr_col <= ctr_col + CW'(1);
                end
            end

            if (accept) begin
                if (last_in) begin
                    in_row <= '0;
                    in_col <= '0;
                end else if (in_col == CW'(IMG_W - 1)) begin
                    in_col <= '0;
                    in_row <= in_row + RW'(1);
                end else begin
                    in_col <= in_col + CW'(1);
                end
            end

            case (state)
                FILL: begin
                    if (accept) begin
                        if (phase_cnt == NW'(H_OFF - 1)) begin
                            state     <= RUN;
                            phase_cnt <= '0;
                        end else begin
                            phase_cnt <= phase_cnt + NW'(1);
                        end
                    end
                end
                RUN: begin
                    if (accept && last_in) begin
                        state   <= FLUSH;
                        ready_q <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (phase_cnt == NW'(H_OFF - 1)) begin
                        state      <= FILL;
                        phase_cnt  <= '0;
                        frame_done <= 1'b1;
                        ctr_row    <= '0;
                        ctr_col    <= '0;
                    end else begin
                        phase_cnt  <= phase_cnt + NW'(1);
                        ready_q    <= 1'b0;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_line_buffer.sv
// tb/tb_window_line_buffer.sv - scoreboard bench for window_line_buffer, zero and replicate borders
module tb_window_line_buffer;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int HOFF = 9;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [7:0]  pixel_in = '0;
    logic        pixel_in_valid = 1'b0;
    logic        rdy_z, rdy_r, vz, vr, dz, dr;
    logic [71:0] wz, wr;
    logic [2:0]  rz, cz, rr, cr;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int exp_q[$];
    logic [71:0] cap_z [NPIX];
    logic [71:0] cap_r [NPIX];
    logic [71:0] ref_z [NPIX];
    logic [71:0] ref_r [NPIX];
    int win_count = 0;
    int done_count = 0;
    int first_cyc = -1;
    int prev_cyc = -100;
    int mon_c, mon_er, mon_ec;

    window_line_buffer #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .K(3), .BORDER(0)) u_zero (
        .clk(clk), .rstN(rstN), .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid),
        .pixel_in_ready(rdy_z), .window_out(wz), .window_out_valid(vz),
        .out_row(rz), .out_col(cz), .frame_done(dz)
    );

    window_line_buffer #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .K(3), .BORDER(1)) u_repl (
        .clk(clk), .rstN(rstN), .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid),
        .pixel_in_ready(rdy_r), .window_out(wr), .window_out_valid(vr),
        .out_row(rr), .out_col(cr), .frame_done(dr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [71:0] w9(input int a0, input int a1, input int a2,
                                       input int a3, input int a4, input int a5,
                                       input int a6, input int a7, input int a8);
        return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic logic [71:0] exp_win(input int r, input int c, input int border);
        logic [71:0] w;
        int sr, sc;
        bit outside;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                sr = r + i - 1;
                sc = c + j - 1;
                outside = (sr < 0) || (sr >= H) || (sc < 0) || (sc >= W);
                if (!(outside && border == 0)) begin
                    sr = (sr < 0) ? 0 : ((sr >= H) ? H - 1 : sr);
                    sc = (sc < 0) ? 0 : ((sc >= W) ? W - 1 : sc);
                    w[(i*3+j)*8 +: 8] = 8'(sr * W + sc);
                end
            end
        end
        return w;
    endfunction

    // Scoreboard: every emitted window pops the expected centre pushed at accept time
    always @(negedge clk) begin
        if (vz || vr || dz || dr) begin
            checks++;
            if (!(vz && vr)) begin
                errors++;
                $display("FAIL valid_pair got vz=%0b vr=%0b dz=%0b dr=%0b required both valid", vz, vr, dz, dr);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_window got row=%0d col=%0d required none", rz, cz);
            end else begin
                mon_c  = exp_q.pop_front();
                mon_er = mon_c / W;
                mon_ec = mon_c % W;
                checks++;
                if ({rz, cz, rr, cr} !== {3'(mon_er), 3'(mon_ec), 3'(mon_er), 3'(mon_ec)}) begin
                    errors++;
                    $display("FAIL coord got (%0d,%0d)/(%0d,%0d) required (%0d,%0d)", rz, cz, rr, cr, mon_er, mon_ec);
                end
                checks++;
                if (wz !== exp_win(mon_er, mon_ec, 0)) begin
                    errors++;
                    $display("FAIL win_zero (%0d,%0d) got %h required %h", mon_er, mon_ec, wz, exp_win(mon_er, mon_ec, 0));
                end
                checks++;
                if (wr !== exp_win(mon_er, mon_ec, 1)) begin
                    errors++;
                    $display("FAIL win_repl (%0d,%0d) got %h required %h", mon_er, mon_ec, wr, exp_win(mon_er, mon_ec, 1));
                end
                checks++;
                if (dz !== (mon_c == NPIX - 1) || dr !== dz) begin
                    errors++;
                    $display("FAIL frame_done (%0d,%0d) got %0b/%0b required %0b", mon_er, mon_ec, dz, dr, mon_c == NPIX - 1);
                end
                if (mon_c >= NPIX - HOFF + 1) begin
                    checks++;
                    if (cyc != prev_cyc + 1) begin
                        errors++;
                        $display("FAIL flush_gap centre %0d got cycle %0d required %0d", mon_c, cyc, prev_cyc + 1);
                    end
                end
                cap_z[mon_c] = wz;
                cap_r[mon_c] = wr;
                win_count++;
                if (dz) done_count++;
                if (first_cyc < 0) first_cyc = cyc;
                prev_cyc = cyc;
            end
        end
    end

    task automatic clear_stats();
        win_count  = 0;
        done_count = 0;
        first_cyc  = -1;
        prev_cyc   = -100;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pixel_in_valid = 1'b0;
        end
    endtask

    task automatic drive_frame(input int gap_pct, input int count, output int wait_first, output int acc10_cyc);
        int n, guard;
        n = 0;
        guard = 0;
        wait_first = 0;
        acc10_cyc = -1;
        while (n < count && guard < 4000) begin
            @(negedge clk);
            guard++;
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                pixel_in_valid = 1'b0;
            end else begin
                pixel_in_valid = 1'b1;
                pixel_in = 8'(n);
                if (rdy_z) begin
                    if (n >= HOFF) exp_q.push_back(n - HOFF);
                    if (n == NPIX - 1) begin
                        for (int m = NPIX - HOFF; m < NPIX; m++) exp_q.push_back(m);
                    end
                    if (n == HOFF) acc10_cyc = cyc;
                    n++;
                end else if (n == 0) begin
                    wait_first++;
                end
            end
        end
        checks++;
        if (n != count) begin
            errors++;
            $display("FAIL drive_timeout got %0d accepts required %0d", n, count);
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        pixel_in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({vz, vr, dz, dr, rdy_z, rdy_r, rz, cz, rr, cr} !== '0 || wz !== '0 || wr !== '0) begin
                errors++;
                $display("FAIL reset_outputs got v=%0b%0b d=%0b%0b rdy=%0b%0b required all zero", vz, vr, dz, dr, rdy_z, rdy_r);
            end
        end
        rstN = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy_z !== 1'b1 || rdy_r !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %0b/%0b required 1", rdy_z, rdy_r);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (vz !== 1'b0 || vr !== 1'b0) begin
                errors++;
                $display("FAIL idle_valid got %0b/%0b required 0", vz, vr);
            end
        end
    endtask

    task automatic test_zero_continuous();
        int wf, a10;
        clear_stats();
        drive_frame(0, NPIX, wf, a10);
        idle(14);
        checks++;
        if (first_cyc != a10 + 1) begin
            errors++;
            $display("FAIL first_latency got cycle %0d required %0d", first_cyc, a10 + 1);
        end
        checks++;
        if (win_count != NPIX || done_count != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL zero_counts got windows=%0d done=%0d pending=%0d required 48/1/0", win_count, done_count, exp_q.size());
        end
        checks++;
        if (cap_z[0] !== w9(0, 0, 0, 0, 0, 1, 0, 8, 9)) begin
            errors++;
            $display("FAIL zero_00 got %h required %h", cap_z[0], w9(0, 0, 0, 0, 0, 1, 0, 8, 9));
        end
        checks++;
        if (cap_z[19] !== w9(10, 11, 12, 18, 19, 20, 26, 27, 28)) begin
            errors++;
            $display("FAIL zero_23 got %h required %h", cap_z[19], w9(10, 11, 12, 18, 19, 20, 26, 27, 28));
        end
        checks++;
        if (cap_z[47] !== w9(38, 39, 0, 46, 47, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL zero_57 got %h required %h", cap_z[47], w9(38, 39, 0, 46, 47, 0, 0, 0, 0));
        end
        for (int m = 0; m < NPIX; m++) begin
            ref_z[m] = cap_z[m];
            ref_r[m] = cap_r[m];
        end
    endtask

    task automatic test_replicate();
        int wf, a10;
        clear_stats();
        drive_frame(0, NPIX, wf, a10);
        idle(14);
        checks++;
        if (win_count != NPIX) begin
            errors++;
            $display("FAIL repl_count got %0d required %0d", win_count, NPIX);
        end
        checks++;
        if (cap_r[0] !== w9(0, 0, 1, 0, 0, 1, 8, 8, 9)) begin
            errors++;
            $display("FAIL repl_00 got %h required %h", cap_r[0], w9(0, 0, 1, 0, 0, 1, 8, 8, 9));
        end
        checks++;
        if (cap_r[47] !== w9(38, 39, 39, 46, 47, 47, 46, 47, 47)) begin
            errors++;
            $display("FAIL repl_57 got %h required %h", cap_r[47], w9(38, 39, 39, 46, 47, 47, 46, 47, 47));
        end
        checks++;
        if (cap_r[19] !== w9(10, 11, 12, 18, 19, 20, 26, 27, 28)) begin
            errors++;
            $display("FAIL repl_23 got %h required %h", cap_r[19], w9(10, 11, 12, 18, 19, 20, 26, 27, 28));
        end
    endtask

    task automatic test_random_gaps();
        int wf, a10, bad;
        clear_stats();
        drive_frame(50, NPIX, wf, a10);
        idle(14);
        bad = 0;
        for (int m = 0; m < NPIX; m++) begin
            if (cap_z[m] !== ref_z[m] || cap_r[m] !== ref_r[m]) bad++;
        end
        checks++;
        if (win_count != NPIX || done_count != 1 || bad != 0) begin
            errors++;
            $display("FAIL gaps_sequence got windows=%0d done=%0d differing=%0d required 48/1/0", win_count, done_count, bad);
        end
    endtask

    task automatic test_back_to_back();
        int wf, a10;
        clear_stats();
        drive_frame(0, NPIX, wf, a10);
        drive_frame(0, NPIX, wf, a10);
        idle(14);
        checks++;
        if (wf != HOFF) begin
            errors++;
            $display("FAIL flush_ready_low got %0d cycles required %0d", wf, HOFF);
        end
        checks++;
        if (win_count != 2 * NPIX || done_count != 2) begin
            errors++;
            $display("FAIL b2b_counts got windows=%0d done=%0d required 96/2", win_count, done_count);
        end
        checks++;
        if (cap_z[0] !== w9(0, 0, 0, 0, 0, 1, 0, 8, 9) || cap_r[0] !== w9(0, 0, 1, 0, 0, 1, 8, 8, 9)) begin
            errors++;
            $display("FAIL b2b_first_window got %h/%h required %h/%h", cap_z[0], cap_r[0],
                     w9(0, 0, 0, 0, 0, 1, 0, 8, 9), w9(0, 0, 1, 0, 0, 1, 8, 8, 9));
        end
    endtask

    task automatic test_reset_abort();
        int wf, a10, bad;
        clear_stats();
        drive_frame(0, 20, wf, a10);
        @(negedge clk);
        pixel_in_valid = 1'b0;
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        drive_frame(0, NPIX, wf, a10);
        idle(14);
        bad = 0;
        for (int m = 0; m < NPIX; m++) begin
            if (cap_z[m] !== ref_z[m] || cap_r[m] !== ref_r[m]) bad++;
        end
        checks++;
        if (win_count != 11 + NPIX || done_count != 1 || bad != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL abort_frame got windows=%0d done=%0d differing=%0d pending=%0d required 59/1/0/0",
                     win_count, done_count, bad, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_zero_continuous();
        test_replicate();
        test_random_gaps();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        checks++;
        $display("FAIL watchdog got no completion required finish before 100000");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
